// File: rtl/logic_unit_pkg.sv
// Shared types for the pipelined bitwise logic unit: op encoding, result flags and flag helper.
// Pure definitions, no state; the helper folds to plain reduction trees for a constant width.
package logic_unit_pkg;

  // Widest result the flag helper handles; wider results are truncated before flagging.
  localparam int LU_MAX_WIDTH = 1024;

  typedef enum logic [2:0] {
    LU_AND   = 3'b000,
    LU_OR    = 3'b001,
    LU_NAND  = 3'b010,
    LU_NOR   = 3'b011,
    LU_XOR   = 3'b100,
    LU_XNOR  = 3'b101,
    LU_ANDN  = 3'b110,
    LU_PASSA = 3'b111
  } lu_op_e;

  typedef struct packed {
    logic zero;
    logic ones;
    logic parity;
  } lu_flags_t;

  // Bits above `width` are masked so they neither clear `ones` nor disturb zero/parity.
  function automatic lu_flags_t lu_flags(input logic [LU_MAX_WIDTH-1:0] res, input int width);
    logic [LU_MAX_WIDTH-1:0] mask;
    lu_flags_t               f;
    mask     = {LU_MAX_WIDTH{1'b1}} >> (LU_MAX_WIDTH - width);
    f.zero   = ~|(res & mask);
    f.ones   = &(res | ~mask);
    f.parity = ^(res & mask);
    return f;
  endfunction

endpackage

// File: rtl/logic_unit_pipe_bitwise_op.sv
// Combinational WIDTH-bit op mux sitting between the two pipeline registers.
// Zero latency, no state, no handshake of its own.
module bitwise_op
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  lu_op_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res
);

  always_comb begin
    res = a;
    case (op)
      LU_AND:   res = a & b;
      LU_OR:    res = a | b;
      LU_NAND:  res = ~(a & b);
      LU_NOR:   res = ~(a | b);
      LU_XOR:   res = a ^ b;
      LU_XNOR:  res = ~(a ^ b);
      LU_ANDN:  res = a & ~b;
      LU_PASSA: res = a;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit with zero/ones/parity flags; latency 2 cycles, 1 beat/cycle.
// Backpressure: in_ready is a combinational chain from out_ready through both stage valids.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity
);

  logic                    s1_valid_q, s1_valid_d;
  lu_op_e                  s1_op_q, s1_op_d;
  logic [WIDTH-1:0]        s1_a_q, s1_a_d;
  logic [WIDTH-1:0]        s1_b_q, s1_b_d;
  logic                    s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]        s2_result_q, s2_result_d;
  lu_flags_t               s2_flags_q, s2_flags_d;
  logic [WIDTH-1:0]        op_res;
  logic [LU_MAX_WIDTH-1:0] res_ext;
  logic                    s1_adv, s2_adv;

  bitwise_op #(.WIDTH(WIDTH)) u_bitwise_op (
    .op  (s1_op_q),
    .a   (s1_a_q),
    .b   (s1_b_q),
    .res (op_res)
  );

  always_comb begin
    s2_adv   = !s2_valid_q | out_ready;
    s1_adv   = !s1_valid_q | s2_adv;
    in_ready = s1_adv;

    s1_valid_d  = s1_adv ? in_valid : s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    // Operands only load with a real beat, so X on idle inputs never enters the datapath.
    if (s1_adv && in_valid) begin
      s1_op_d = lu_op_e'(in_op);
      s1_a_d  = in_a;
      s1_b_d  = in_b;
    end

    s2_valid_d  = s2_adv ? s1_valid_q : s2_valid_q;
    s2_result_d = s2_result_q;
    s2_flags_d  = s2_flags_q;
    res_ext     = LU_MAX_WIDTH'(op_res);
    if (s2_adv && s1_valid_q) begin
      s2_result_d = op_res;
      s2_flags_d  = lu_flags(res_ext, WIDTH);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_op_q     <= s1_op_d;
    s1_a_q      <= s1_a_d;
    s1_b_q      <= s1_b_d;
    s2_result_q <= s2_result_d;
    s2_flags_q  <= s2_flags_d;
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_zero   = s2_flags_q.zero;
  assign out_ones   = s2_flags_q.ones;
  assign out_parity = s2_flags_q.parity;

endmodule
